regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port (write_reg/write_data/signal_reg_write) among N

---
 rtl/rf_arb_pkg.sv | 22 ++
 rtl/rr_priority_picker.sv | 30 +++
 rtl/regfile_write_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared widths, FSM state type and pointer helper for the register-file write arbiter
package rf_arb_pkg;

    localparam int RF_ADDR_W  = 5;
    localparam int RF_DATA_W  = 32;
    localparam int GRANT_W    = 3;
    localparam int LOCK_CNT_W = 4;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Advance a requester index by one, wrapping at n.
    function automatic logic [GRANT_W-1:0] ptr_inc(input logic [GRANT_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + GRANT_W'(1);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker: first valid at or above ptr, wrapping
module rr_priority_picker
    import rf_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]       valid_i,
    input  logic [GRANT_W-1:0] ptr_i,
    output logic [N-1:0]       grant_o,
    output logic [GRANT_W-1:0] idx_o,
    output logic               any_o
);

    always_comb begin
        int j;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!any_o && valid_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = GRANT_W'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin owner of the register-file write port with bounded locks
// Optional RF_ARB_FWD_EN adds same-cycle forwarding of the registered write to two read ports.
module regfile_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int LOCK_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_lock,
    input  logic [N_REQ*RF_ADDR_W-1:0] req_reg,
    input  logic [N_REQ*RF_DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       rf_hold,
`ifdef RF_ARB_FWD_EN
    input  logic [RF_ADDR_W-1:0]       fwd_rd_reg_1,
    input  logic [RF_ADDR_W-1:0]       fwd_rd_reg_2,
    output logic                       fwd_hit_1,
    output logic                       fwd_hit_2,
    output logic [RF_DATA_W-1:0]       fwd_data_1,
    output logic [RF_DATA_W-1:0]       fwd_data_2,
`endif
    output logic                       signal_reg_write,
    output logic [RF_ADDR_W-1:0]       write_reg,
    output logic [RF_DATA_W-1:0]       write_data,
    output logic [GRANT_W-1:0]         grant_id
);

    arb_state_e             state_q, state_d;
    logic [GRANT_W-1:0]     ptr_q, ptr_d, owner_q, owner_d;
    logic [LOCK_CNT_W-1:0]  cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [RF_ADDR_W-1:0]   wreg_q, wreg_d;
    logic [RF_DATA_W-1:0]   wdata_q, wdata_d;
    logic [GRANT_W-1:0]     gid_q, gid_d;

    logic [N_REQ-1:0]       elig, pick_grant;
    logic [GRANT_W-1:0]     pick_idx;
    logic                   pick_any, xfer, sel_lock;
    logic [RF_ADDR_W-1:0]   sel_reg;
    logic [RF_DATA_W-1:0]   sel_data;

    // While locked only the owner is visible to the picker, so ptr can stay frozen.
    assign elig = (state_q == ST_LOCKED) ? (req_valid & (N_REQ'(1) << owner_q)) : req_valid;

    rr_priority_picker #(.N(N_REQ)) u_picker (
        .valid_i (elig),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign xfer     = rst_n & pick_any & ~rf_hold;
    assign sel_lock = req_lock[pick_idx];
    assign sel_reg  = req_reg[pick_idx*RF_ADDR_W +: RF_ADDR_W];
    assign sel_data = req_data[pick_idx*RF_DATA_W +: RF_DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            gid_q   <= gid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            unique case (state_q)
                ST_ARB: begin
                    ptr_d = ptr_inc(pick_idx, N_REQ);
                    if (sel_lock && (LOCK_MAX > 1)) begin
                        state_d = ST_LOCKED;
                        owner_d = pick_idx;
                        cnt_d   = LOCK_CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    cnt_d = cnt_q + LOCK_CNT_W'(1);
                    if (!sel_lock || (cnt_d == LOCK_CNT_W'(LOCK_MAX))) begin
                        state_d = ST_ARB;
                        cnt_d   = '0;
                        ptr_d   = ptr_inc(owner_q, N_REQ);
                    end
                end
                default: state_d = ST_ARB;
            endcase
        end
    end

    // r0 transfers are consumed but never raise the write enable.
    always_comb begin
        req_ready = xfer ? pick_grant : '0;
        we_d      = xfer && (sel_reg != '0);
        wreg_d    = xfer ? sel_reg  : wreg_q;
        wdata_d   = xfer ? sel_data : wdata_q;
        gid_d     = xfer ? pick_idx : gid_q;
    end

    assign signal_reg_write = we_q;
    assign write_reg        = wreg_q;
    assign write_data       = wdata_q;
    assign grant_id         = gid_q;

`ifdef RF_ARB_FWD_EN
    assign fwd_hit_1  = we_q && (wreg_q == fwd_rd_reg_1) && (wreg_q != '0);
    assign fwd_hit_2  = we_q && (wreg_q == fwd_rd_reg_2) && (wreg_q != '0);
    assign fwd_data_1 = wdata_q;
    assign fwd_data_2 = wdata_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed and randomized checks of regfile_write_arbiter against a behavioural model
module tb_regfile_write_arbiter;

    localparam int N  = 4;
    localparam int LM = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_lock, req_ready;
    logic [N*5-1:0]  req_reg;
    logic [N*32-1:0] req_data;
    logic            rf_hold;
    logic            srw;
    logic [4:0]      wr;
    logic [31:0]     wd;
    logic [2:0]      gid;
`ifdef RF_ARB_FWD_EN
    logic [4:0]      f1, f2;
    logic            h1, h2;
    logic [31:0]     fd1, fd2;
`endif

    always #5 clk = ~clk;

    regfile_write_arbiter #(.N_REQ(N), .LOCK_MAX(LM)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_lock         (req_lock),
        .req_reg          (req_reg),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .rf_hold          (rf_hold),
`ifdef RF_ARB_FWD_EN
        .fwd_rd_reg_1     (f1),
        .fwd_rd_reg_2     (f2),
        .fwd_hit_1        (h1),
        .fwd_hit_2        (h2),
        .fwd_data_1       (fd1),
        .fwd_data_2       (fd2),
`endif
        .signal_reg_write (srw),
        .write_reg        (wr),
        .write_data       (wd),
        .grant_id         (gid)
    );

    int total = 0;
    int bad   = 0;

    bit          m_locked;
    int          m_ptr, m_owner, m_cnt;
    bit          e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    int          e_gid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
        e_we = 0; e_reg = '0; e_data = '0; e_gid = 0;
    endtask

    task automatic set_req(input int i, input bit v, input bit l, input logic [4:0] r, input logic [31:0] d);
        req_valid[i]      = v;
        req_lock[i]       = l;
        req_reg[i*5 +: 5] = r;
        req_data[i*32 +: 32] = d;
    endtask

    // One clock: check ready against the model, clock, then check the registered write.
    task automatic cycle(output int xw);
        int w;
        logic [N-1:0] er;
        bit lk;
        #1;
        w = -1;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (w < 0 && req_valid[j] && (!m_locked || j == m_owner)) w = j;
            end
        end
        er = '0;
        xw = (w >= 0 && !rf_hold && rst_n) ? w : -1;
        if (xw >= 0) er[xw] = 1'b1;
        chk("ready", req_ready, er);
        @(posedge clk);
        if (xw >= 0) begin
            lk     = req_lock[xw];
            e_reg  = req_reg[xw*5 +: 5];
            e_data = req_data[xw*32 +: 32];
            e_we   = (e_reg != 0);
            e_gid  = xw;
            if (!m_locked) begin
                m_ptr = (xw + 1) % N;
                if (lk && LM > 1) begin
                    m_locked = 1; m_owner = xw; m_cnt = 1;
                end
            end else begin
                m_cnt++;
                if (!lk || m_cnt == LM) begin
                    m_locked = 0; m_ptr = (m_owner + 1) % N;
                end
            end
        end else begin
            e_we = 0;
        end
        #1;
        chk("we", srw, e_we);
        if (e_we) begin
            chk("write_reg", wr, e_reg);
            chk("write_data", wd, e_data);
            chk("grant_id", gid, e_gid);
        end
`ifdef RF_ARB_FWD_EN
        chk("fwd_hit_1", h1, e_we && (e_reg == f1));
        chk("fwd_hit_2", h2, e_we && (e_reg == f2));
        if (e_we) chk("fwd_data_1", fd1, e_data);
`endif
    endtask

    task automatic do_reset();
        int xw;
        rst_n = 1'b0;
        model_reset();
        cycle(xw);
        rst_n = 1'b1;
    endtask

    initial begin
        int xw;
        int exp3 [5];
        bit [31:0] pend_r;
        rst_n = 1'b0; rf_hold = 1'b0;
        req_valid = '1; req_lock = '0; req_reg = '0; req_data = '0;
`ifdef RF_ARB_FWD_EN
        f1 = 5'd0; f2 = 5'd0;
`endif
        model_reset();
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 5'(i + 1), 32'h1000 + i);
        #1;
        chk("t1_ready_in_reset", req_ready, 4'b0000);
        chk("t1_we_in_reset", srw, 1'b0);
        chk("t1_gid_in_reset", gid, 3'd0);
        cycle(xw);
        cycle(xw);
        rst_n = 1'b1;
        cycle(xw);
        chk("t1_first_grant", xw, 0);

        // Round robin across all four, no locks.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(xw);
            chk("t2_grant", xw, k % 4);
            chk("t2_reg", wr, 5'(k % 4 + 1));
        end

        // req2 takes a lock and is forced out after four transfers.
        do_reset();
        exp3 = '{2, 2, 2, 2, 3};
        req_valid = 4'b0100; req_lock = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            cycle(xw);
            chk("t3_grant", xw, exp3[k]);
            req_valid = 4'b1111;
        end

        // req1 locks, drops valid for three cycles, then releases with lock=0.
        do_reset();
        req_valid = 4'b0010; req_lock = 4'b0010;
        cycle(xw);
        chk("t4_lock_grant", xw, 1);
        req_valid = 4'b1101; req_lock = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            cycle(xw);
            chk("t4_gap", xw, -1);
        end
        req_valid = 4'b1111;
        cycle(xw);
        chk("t4_release_grant", xw, 1);
        cycle(xw);
        chk("t4_after_release", xw, 2);

        // Hold freezes everything; r0 transfer is consumed without a write.
        do_reset();
        cycle(xw);
        chk("t5_pre", xw, 0);
        rf_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(xw);
            chk("t5_hold_ready", req_ready, 4'b0000);
            chk("t5_hold_we", srw, 1'b0);
        end
        rf_hold = 1'b0;
        set_req(1, 0, 0, 5'd2, 32'h1001);
        set_req(2, 1, 0, 5'd0, 32'hABCD0000);
        cycle(xw);
        chk("t5_r0_grant", xw, 2);
        chk("t5_r0_we", srw, 1'b0);
        set_req(2, 1, 0, 5'd3, 32'h1002);

`ifdef RF_ARB_FWD_EN
        do_reset();
        req_valid = 4'b0001; req_lock = '0;
        set_req(0, 1, 0, 5'd5, 32'hDEADBEEF);
        f1 = 5'd5;
        cycle(xw);
        chk("t6_hit", h1, 1'b1);
        chk("t6_data", fd1, 32'hDEADBEEF);
        set_req(0, 1, 0, 5'd0, 32'h12345678);
        f1 = 5'd0;
        cycle(xw);
        chk("t6_r0_hit", h1, 1'b0);
`endif

        // Randomized traffic; a pending request keeps its reg/data until taken.
        do_reset();
        req_valid = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    pend_r = $urandom;
                    set_req(i, 1, req_lock[i], 5'(pend_r), $urandom);
                end
                req_lock[i] = ($urandom_range(2, 0) == 0);
            end
            rf_hold = ($urandom_range(7, 0) == 0);
`ifdef RF_ARB_FWD_EN
            f1 = 5'($urandom); f2 = 5'($urandom);
`endif
            if ($urandom_range(499, 0) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            cycle(xw);
            if (xw >= 0) req_valid[xw] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
